// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, STAGES carry-pipelined chunks; optional saturation via PIPELINED_ADDER_SAT_EN.
// Latency: STAGES cycles from input handshake to output handshake, one result per cycle when streaming.
// Backpressure: ready ripples back combinationally (ready_k = !valid_k | ready_k+1); in_ready never depends on in_valid.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);
    localparam int CW = WIDTH / STAGES;

    // Subtract is A + ~B + !borrow, so B and cin are conditioned once on entry.
    logic [WIDTH-1:0] b_cond;
    assign b_cond = in_b ^ {WIDTH{in_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // s_q holds the low (k+1) chunks of the result; rem carries the chunks not yet added.
        localparam int SW = (k + 1) * CW;
        localparam int RW = WIDTH - SW;
        localparam bit LAST = (k == STAGES - 1);

        logic [CW-1:0] a_c;
        logic [CW-1:0] b_c;
        logic          c_in;
        logic          vld_in;
        logic          rdy_dn;
        logic          rdy;
        logic          ld;
        logic [CW:0]   add;
        logic [SW-1:0] s_nxt;
        logic [SW-1:0] s_ld;
        logic [SW-1:0] s_q;
        logic          v_q;
        logic          c_q;

        if (k == 0) begin : src
            assign a_c    = in_a[CW-1:0];
            assign b_c    = b_cond[CW-1:0];
            assign c_in   = in_cin ^ in_sub;
            assign vld_in = in_valid;
            assign s_nxt  = add[CW-1:0];
        end else begin : src
            assign a_c    = stg[k-1].rem.a_q[CW-1:0];
            assign b_c    = stg[k-1].rem.b_q[CW-1:0];
            assign c_in   = stg[k-1].c_q;
            assign vld_in = stg[k-1].v_q;
            assign s_nxt  = {add[CW-1:0], stg[k-1].s_q};
        end

        if (k == STAGES - 1) begin : dn
            assign rdy_dn = out_ready;
        end else begin : dn
            assign rdy_dn = stg[k+1].rdy;
        end

        assign add = {1'b0, a_c} + {1'b0, b_c} + {{CW{1'b0}}, c_in};
        assign rdy = !v_q | rdy_dn;
        assign ld  = rdy & vld_in;

        if (RW > 0) begin : rem
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic [RW-1:0] a_nxt;
            logic [RW-1:0] b_nxt;
            if (k == 0) begin : nx
                assign a_nxt = in_a[WIDTH-1:CW];
                assign b_nxt = b_cond[WIDTH-1:CW];
            end else begin : nx
                assign a_nxt = stg[k-1].rem.a_q[RW+CW-1:CW];
                assign b_nxt = stg[k-1].rem.b_q[RW+CW-1:CW];
            end
            // carry the not-yet-added operand chunks forward with the transaction
            always_ff @(posedge clk) begin
                if (ld) begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                end
            end
`ifdef PIPELINED_ADDER_SAT_EN
            // the sub flag is only needed downstream to pick the saturation direction
            logic sub_q;
            if (k == 0) begin : sx
                // latch the mode bit of the accepted transaction
                always_ff @(posedge clk) begin
                    if (ld) sub_q <= in_sub;
                end
            end else begin : sx
                // pass the mode bit along with its transaction
                always_ff @(posedge clk) begin
                    if (ld) sub_q <= stg[k-1].rem.sub_q;
                end
            end
`endif
        end

        if (LAST) begin : fin
`ifdef PIPELINED_ADDER_SAT_EN
            logic sub_f;
            if (k == 0) begin : sf
                assign sub_f = in_sub;
            end else begin : sf
                assign sub_f = stg[k-1].rem.sub_q;
            end
            // clamp on add overflow or subtract underflow; the raw carry is still reported
            always_comb begin
                s_ld = s_nxt;
                if (!sub_f && add[CW])
                    s_ld = '1;
                else if (sub_f && !add[CW])
                    s_ld = '0;
            end
`else
            assign s_ld = s_nxt;
`endif
        end else begin : fin
            assign s_ld = s_nxt;
        end

        // valid bit advances whenever this stage can hand off or is empty
        always_ff @(posedge clk) begin
            if (rst)
                v_q <= 1'b0;
            else if (rdy)
                v_q <= vld_in;
        end

        // partial sum and chunk carry; the final stage doubles as the cleared output register
        always_ff @(posedge clk) begin
            if (LAST && rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (ld) begin
                s_q <= s_ld;
                c_q <= add[CW];
            end
        end
    end

    assign in_ready  = stg[0].rdy;
    assign out_valid = stg[STAGES-1].v_q;
    assign out_sum   = stg[STAGES-1].s_q;
    assign out_cout  = stg[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: scoreboard of expected results in acceptance order,
// latency/hold/in_ready checks on a 32/4 instance, reset-mid-stall on an 8/2 instance.
module tb_pipelined_adder;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_sum;
    logic        out_cout;

    logic        rst8 = 1'b1;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        cin8 = 1'b0;
    logic        sub8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [7:0]  out_sum8;
    logic        out_cout8;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          acc_edge;
    } exp_t;
    exp_t sb[$];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_sum;
    logic        prev_cout;

    pipelined_adder #(.WIDTH(32), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst8),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_sum(out_sum8), .out_cout(out_cout8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: add is the full-precision sum; subtract uses ordinary comparison and difference.
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic cin, input logic sub);
        logic [63:0] mask;
        logic [63:0] full;
        logic [63:0] s;
        logic        co;
        mask = (64'd1 << w) - 64'd1;
        if (!sub) begin
            full = {32'd0, a} + {32'd0, b} + 64'(cin);
            co   = full[w];
            s    = full & mask;
        end else begin
            co = ({32'd0, a} >= ({32'd0, b} + 64'(cin)));
            s  = ({32'd0, a} - {32'd0, b} - 64'(cin)) & mask;
        end
`ifdef PIPELINED_ADDER_SAT_EN
        if (!sub && co) s = mask;
        if (sub && !co) s = '0;
`endif
        return {co, s[31:0]};
    endfunction

    // Monitor for the 32-bit instance: sampled on the falling edge, describing the next rising edge.
    always @(negedge clk) begin
        logic [32:0] r;
        exp_t e;
        if (!rst) begin
            check("in_ready", 64'(in_ready), 64'(out_ready || (sb.size() < STAGES)));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_sum", 64'(out_sum), 64'(prev_sum));
                check("stall_cout", 64'(out_cout), 64'(prev_cout));
            end
            if (out_valid && out_ready) begin
                check("spurious_out", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sum", 64'(out_sum), 64'(e.sum));
                    check("cout", 64'(out_cout), 64'(e.cout));
                    if (lat_chk) check("latency", 64'(cyc + 1 - e.acc_edge), 64'(STAGES));
                end
            end
            if (in_valid && in_ready) begin
                r = ref_add(32, in_a, in_b, in_cin, in_sub);
                sb.push_back('{sum: r[31:0], cout: r[32], acc_edge: cyc + 1});
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_cout  = out_cout;
        end else begin
            sb.delete();
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that accepted the transaction.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bit acc = 1'b0;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit stale;
        bit got;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_cout", 64'(out_cout), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst8 = 1'b0;

        // directed: carry across chunk boundary, full wrap, subtract with and without borrow
        lat_chk = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        send(32'd5, 32'd7, 1'b0, 1'b1);
        send(32'd7, 32'd5, 1'b1, 1'b1);
        drain();

        // back-to-back stream, no backpressure
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();

        // same stream with random backpressure
        lat_chk = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // 8-bit/2-stage: reset while two transactions stall in the pipe
        in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        a8 = 8'h33; b8 = 8'h01;
        @(posedge clk); #1;
        check("w8_inflight_valid", 64'(out_valid8), 64'd1);
        check("w8_full_in_ready", 64'(in_ready8), 64'd0);
        a8 = 8'h44; rst8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; rst8 = 1'b0;
        check("w8_rst_valid", 64'(out_valid8), 64'd0);
        check("w8_rst_sum", 64'(out_sum8), 64'd0);
        check("w8_rst_cout", 64'(out_cout8), 64'd0);
        check("w8_rst_in_ready", 64'(in_ready8), 64'd1);
        out_ready8 = 1'b1;
        stale = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stale |= out_valid8;
        end
        check("w8_no_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid8) got = 1'b1;
        end
        check("w8_result_seen", 64'(got), 64'd1);
`ifdef PIPELINED_ADDER_SAT_EN
        check("w8_sum", 64'(out_sum8), 64'hFF);
`else
        check("w8_sum", 64'(out_sum8), 64'h00);
`endif
        check("w8_cout", 64'(out_cout8), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
